// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter with overflow flag
// Optional leading-zero blank flags are built only when BCD_BLANK_EN is defined.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    acc_nxt;
  logic             ovf_acc;
  logic             ovf_nxt;
  logic [CW-1:0]    cnt;
  logic             last_shift;

  // A carry out of the top digit means the partial value already reached
  // 10^DIGITS; it only grows from there, so a sticky OR is a complete flag.
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    acc_nxt = {adj[BW-2:0], bin_sr[WIDTH-1]};
    ovf_nxt = ovf_acc | adj[BW-1];
  end

  assign last_shift = (state == SHIFT) && (cnt == CW'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      bin_sr   <= '0;
      acc      <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          bin_sr  <= bin;
          acc     <= '0;
          ovf_acc <= 1'b0;
          cnt     <= CW'(WIDTH);
          busy    <= 1'b1;
          state   <= SHIFT;
        end
      end else begin
        bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
        acc     <= acc_nxt;
        ovf_acc <= ovf_nxt;
        cnt     <= cnt - CW'(1);
        if (last_shift) begin
          bcd      <= acc_nxt;
          overflow <= ovf_nxt;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      end
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;

  // Scan from the top digit down; the ones digit is never blanked.
  always_comb begin
    logic zero;
    zero      = 1'b1;
    blank_nxt = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero         = zero & (acc_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = zero & ~ovf_nxt;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      blank <= '0;
    end else if (last_shift) begin
      blank <= blank_nxt;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
// Expected blank values follow BCD_BLANK_EN when it is defined for the build.
module tb_bin_to_bcd_seq;

`ifdef BCD_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;
  logic [3:0]  blank;

  int vectors = 0;
  int miscompares = 0;

  bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow),
    .blank    (blank)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic conv(input logic [13:0] b, input logic [15:0] eb, input logic eo,
                      input logic [3:0] ebl, input string tag);
    int edges;
    bit got;
    @(negedge clock);
    bin   = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    bin   = ~b;
    check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clock);
      edges++;
      #1;
      if (done) got = 1'b1;
    end
    check({tag, " latency"}, 32'(edges), 32'd14);
    check({tag, " bcd"}, 32'(bcd), 32'(eb));
    check({tag, " overflow"}, 32'(overflow), 32'(eo));
    check({tag, " blank"}, 32'(blank), BLANK_EN ? 32'(ebl) : 32'd0);
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    int last_done;
    int bad;

    resetn = 1'b0;
    start  = 1'b0;
    bin    = '0;
    #12;
    @(negedge clock);
    resetn = 1'b1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset bcd", 32'(bcd), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset blank", 32'(blank), 32'd0);

    conv(14'd0,    16'h0000, 1'b0, 4'b1110, "bin0");
    conv(14'd9999, 16'h9999, 1'b0, 4'b0000, "bin9999");
    conv(14'd56,   16'h0056, 1'b0, 4'b1100, "bin56");

    // Abort a conversion of 1234 mid-shift with an asynchronous reset.
    @(negedge clock);
    bin   = 14'd1234;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset bcd", 32'(bcd), 32'd0);
    check("midreset overflow", 32'(overflow), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    dones = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clock);
      #1;
      if (done) dones++;
    end
    check("midreset no_done", 32'(dones), 32'd0);
    conv(14'd1234,  16'h1234, 1'b0, 4'b0000, "bin1234");
    conv(14'd10000, 16'h0000, 1'b1, 4'b0000, "bin10000");
    conv(14'd16383, 16'h6383, 1'b1, 4'b0000, "bin16383");

    // Start pulses at cycles 3 and 8 of a busy conversion are ignored.
    @(negedge clock);
    bin   = 14'd4321;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    dones = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clock);
      start = (e == 3 || e == 8);
      bin   = 14'(e);
      @(posedge clock);
      #1;
      if (done) dones++;
    end
    start = 1'b0;
    check("busy_start done_count", 32'(dones), 32'd1);
    check("busy_start bcd", 32'(bcd), 32'h4321);

    // Start held high: back-to-back conversions every 15 cycles.
    @(negedge clock);
    bin   = 14'd1234;
    start = 1'b1;
    dones = 0;
    last_done = 0;
    bad = 0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clock);
      #1;
      if (busy === done) bad++;
      if (done) begin
        dones++;
        check("held bcd", 32'(bcd), 32'h1234);
        if (dones > 1) check("held period", 32'(e - last_done), 32'd15);
        last_done = e;
      end
    end
    check("held done_count", 32'(dones), 32'd3);
    check("held busy_vs_done", 32'(bad), 32'd0);
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
